keypad_emulator: RTL and testbench

Synthesizable model of the 4x4 matrix keypad, sitting on the far side of the `row`/`col` interface from the keypad scanner. It senses the scanner's active-low column drive and returns active-low row lines as a physical keypad would. Presses are commanded over a valid/ready port, with programmable hold time and optional pseudo-random contact bounce. It is used for in-system self-test and as the bench's keypad stand-in.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/lfsr8.sv | 37 +++
 rtl/keypad_emulator.sv | 197 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
//==============================================================================
// Package  : keypad_pkg
// Brief    : Shared types, key map and LFSR taps for the keypad emulator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HELD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Returns {row[1:0], col[1:0]} of a hex key on the physical 4x4 matrix.
    function automatic logic [3:0] key_pos(input logic [3:0] key);
        logic [3:0] pos;
        pos = 4'b0000;
        case (key)
            4'h1: pos = 4'b00_00;
            4'h2: pos = 4'b00_01;
            4'h3: pos = 4'b00_10;
            4'hA: pos = 4'b00_11;
            4'h4: pos = 4'b01_00;
            4'h5: pos = 4'b01_01;
            4'h6: pos = 4'b01_10;
            4'hB: pos = 4'b01_11;
            4'h7: pos = 4'b10_00;
            4'h8: pos = 4'b10_01;
            4'h9: pos = 4'b10_10;
            4'hC: pos = 4'b10_11;
            4'hE: pos = 4'b11_00;
            4'h0: pos = 4'b11_01;
            4'hF: pos = 4'b11_10;
            4'hD: pos = 4'b11_11;
        endcase
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
//==============================================================================
// Module   : lfsr8
// Brief    : Free-running seeded 8-bit Fibonacci LFSR used for bounce counts.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr8
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/keypad_emulator.sv
//==============================================================================
// Module   : keypad_emulator
// Brief    : 4x4 matrix keypad model; presses commanded over valid/ready.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         BOUNCE_PERIOD = 16,
    parameter int         GAP_CYCLES    = 64,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic        cmd_bounce,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        busy,
    output logic        done
);

    localparam int CNT_MAX = (BOUNCE_PERIOD > GAP_CYCLES) ? BOUNCE_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BP_LOAD  = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0]        pulses_q, pulses_d;
    logic              phase_q, phase_d;
    logic [3:0]        key_q, key_d;
    logic              bounce_q, bounce_d;
    logic              contact_q, contact_d;
    logic              done_q, done_d;

    logic [7:0]        lfsr_state;
    logic [1:0]        n_in;
    logic [1:0]        n_out;
    logic [3:0]        pos;
    logic              unused_lfsr;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (reset),
        .state (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state[7:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        pulses_d   = pulses_q;
        phase_d    = phase_q;
        key_d      = key_q;
        bounce_d   = bounce_q;
        contact_d  = contact_q;
        done_d     = 1'b0;
        n_in       = cmd_bounce ? lfsr_state[1:0] : 2'd0;
        n_out      = bounce_q   ? lfsr_state[1:0] : 2'd0;

        case (state_q)
            ST_IDLE: begin
                contact_d = 1'b0;
                if (cmd_valid) begin
                    key_d      = cmd_key;
                    bounce_d   = cmd_bounce;
                    // Loaded now, only counted down in HELD; a zero hold still gives one cycle.
                    hold_cnt_d = (cmd_hold == 16'd0) ? 16'd0 : cmd_hold - 16'd1;
                    contact_d  = 1'b1;
                    if (n_in != 2'd0) begin
                        state_d  = ST_BOUNCE_IN;
                        pulses_d = n_in;
                        phase_d  = 1'b0;
                        cnt_d    = BP_LOAD;
                    end else begin
                        state_d  = ST_HELD;
                    end
                end
            end
            ST_BOUNCE_IN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!phase_q) begin
                    phase_d   = 1'b1;
                    cnt_d     = BP_LOAD;
                    contact_d = 1'b0;
                end else if (pulses_q == 2'd1) begin
                    state_d   = ST_HELD;
                    contact_d = 1'b1;
                end else begin
                    pulses_d  = pulses_q - 2'd1;
                    phase_d   = 1'b0;
                    cnt_d     = BP_LOAD;
                    contact_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (hold_cnt_q != 16'd0) begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end else begin
                    contact_d = 1'b0;
                    if (n_out != 2'd0) begin
                        state_d  = ST_BOUNCE_OUT;
                        pulses_d = n_out;
                        phase_d  = 1'b0;
                        cnt_d    = BP_LOAD;
                    end else begin
                        state_d  = ST_GAP;
                        cnt_d    = GAP_LOAD;
                    end
                end
            end
            ST_BOUNCE_OUT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!phase_q) begin
                    phase_d   = 1'b1;
                    cnt_d     = BP_LOAD;
                    contact_d = 1'b1;
                end else if (pulses_q == 2'd1) begin
                    state_d   = ST_GAP;
                    cnt_d     = GAP_LOAD;
                    contact_d = 1'b0;
                end else begin
                    pulses_d  = pulses_q - 2'd1;
                    phase_d   = 1'b0;
                    cnt_d     = BP_LOAD;
                    contact_d = 1'b0;
                end
            end
            ST_GAP: begin
                contact_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= 16'd0;
            pulses_q   <= 2'd0;
            phase_q    <= 1'b0;
            key_q      <= 4'h0;
            bounce_q   <= 1'b0;
            contact_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            pulses_q   <= pulses_d;
            phase_q    <= phase_d;
            key_q      <= key_d;
            bounce_q   <= bounce_d;
            contact_q  <= contact_d;
            done_q     <= done_d;
        end
    end

    // Combinational from col, like a real switch closing a row to a column.
    always_comb begin
        pos = key_pos(key_q);
        row = 4'hF;
        if (contact_q && !col[pos[1:0]]) begin
            row[pos[3:2]] = 1'b0;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
//==============================================================================
// Module   : tb_keypad_emulator
// Brief    : Directed self-checking bench for keypad_emulator.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_emulator;

    localparam int         BP   = 4;
    localparam int         GAP  = 10;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic        cmd_bounce;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  m_lfsr;
    logic [3:0]  kmap [16];

    keypad_emulator #(
        .BOUNCE_PERIOD (BP),
        .GAP_CYCLES    (GAP),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_key    (cmd_key),
        .cmd_hold   (cmd_hold),
        .cmd_bounce (cmd_bounce),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference LFSR built from the polynomial exponents 8,6,5,4
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_idle_timeout: cmd_ready=%b required 1", tag, cmd_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = 16'd0;
        cmd_bounce = 1'b0; col = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (row !== 4'hF)    begin fails++; $display("FAIL reset_row: got %h required F", row); end
        checks++; if (cmd_ready !== 1) begin fails++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        checks++; if (busy !== 0)      begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 0)      begin fails++; $display("FAIL reset_done: got %b required 0", done); end
        col   = 4'hF;
        reset = 1'b1;
    endtask

    task automatic test_basic_press;
        int lo_cnt, first_lo, last_lo, done_idx, done_cnt;
        lo_cnt = 0; first_lo = -1; last_lo = -1; done_idx = -1; done_cnt = 0;
        wait_idle("basic");
        cmd_key = 4'h5; cmd_hold = 16'd100; cmd_bounce = 1'b0; col = 4'b1101; cmd_valid = 1'b1;
        for (int i = 0; i < 100 + GAP + 4; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            col = (i == 50) ? 4'b1110 : 4'b1101;
            #1;
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", busy); end
            end
            if (i == 50) begin
                checks++;
                if (row !== 4'hF) begin fails++; $display("FAIL basic_wrong_col: row=%h required F", row); end
            end
            if (row == 4'b1101) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = i;
                last_lo = i;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
        col = 4'hF;
        checks++; if (lo_cnt !== 99)        begin fails++; $display("FAIL basic_low_cycles: got %0d required 99", lo_cnt); end
        checks++; if (first_lo !== 0)       begin fails++; $display("FAIL basic_first_low: got %0d required 0", first_lo); end
        checks++; if (last_lo !== 99)       begin fails++; $display("FAIL basic_last_low: got %0d required 99", last_lo); end
        checks++; if (done_idx !== 100+GAP) begin fails++; $display("FAIL basic_done_cycle: got %0d required %0d", done_idx, 100+GAP); end
        checks++; if (done_cnt !== 1)       begin fails++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_keymap;
        // {row, col} of keys 0..F
        kmap = '{4'hD, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
                 4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hC, 4'hE};
        for (int k = 0; k < 16; k++) begin
            wait_idle("keymap");
            cmd_key = 4'(k); cmd_hold = 16'd8; cmd_bounce = 1'b0; col = 4'hF; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int p = 0; p < 5; p++) begin
                logic [3:0] c;
                logic [3:0] e;
                c = (p == 4) ? 4'h0 : ~(4'b0001 << p);
                col = c;
                #1;
                e = 4'hF;
                if (p == 4 || p == int'(kmap[k][1:0])) e[kmap[k][3:2]] = 1'b0;
                checks++;
                if (row !== e) begin
                    fails++;
                    $display("FAIL keymap key=%h col=%b: row=%b required %b", k[3:0], c, row, e);
                end
                @(negedge clk);
            end
            col = 4'hF;
        end
    endtask

    task automatic test_bounce;
        int n, n_out, i_h, mism, first_bad, falls, done_idx, len;
        logic       prev, expc;
        logic [3:0] e;
        wait_idle("bounce");
        col = 4'b1110; cmd_key = 4'h1; cmd_hold = 16'd20; cmd_bounce = 1'b1;
        n = 0;
        while (m_lfsr[1:0] != 2'd2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL bounce_ready: got %b required 1", cmd_ready); end
        i_h = 4*BP + 19; n_out = 0; mism = 0; first_bad = -1; falls = 0; prev = 1'b1; done_idx = -1;
        len = 4*BP + 20 + 6*BP + GAP + 4;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (i == i_h) n_out = int'(m_lfsr[1:0]);
            #1;
            if (i < 4*BP)                           expc = ((i / BP) % 2 == 0);
            else if (i < 4*BP + 20)                 expc = 1'b1;
            else if (i - (4*BP + 20) < 2*n_out*BP)  expc = (((i - (4*BP + 20)) / BP) % 2 == 1);
            else                                    expc = 1'b0;
            e = {3'b111, ~expc};
            if (row !== e) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
            if (prev && !row[0]) falls++;
            prev = row[0];
            if (done === 1'b1 && done_idx < 0) done_idx = i;
        end
        col = 4'hF;
        checks++; if (mism !== 0) begin fails++; $display("FAIL bounce_trace: %0d bad cycles (first at %0d) required 0", mism, first_bad); end
        checks++; if (falls !== 3 + n_out) begin fails++; $display("FAIL bounce_pulses: got %0d low pulses required %0d", falls, 3 + n_out); end
        checks++;
        if (done_idx !== 4*BP + 20 + 2*n_out*BP + GAP) begin
            fails++;
            $display("FAIL bounce_done_cycle: got %0d required %0d", done_idx, 4*BP + 20 + 2*n_out*BP + GAP);
        end
    endtask

    task automatic test_back_to_back;
        int mism, first_bad, done_cnt, d1, d2;
        logic       rdy_at_d1, bsy_bad;
        logic [3:0] e;
        mism = 0; first_bad = -1; done_cnt = 0; d1 = -1; d2 = -1; rdy_at_d1 = 1'b0; bsy_bad = 1'b0;
        wait_idle("handshake");
        col = 4'b1011; cmd_key = 4'h6; cmd_hold = 16'd0; cmd_bounce = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 2*GAP + 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_key  = 4'h9;
                cmd_hold = 16'd3;
            end
            #1;
            if (i == 0)                                e = 4'b1101;
            else if (i >= GAP + 2 && i <= GAP + 4)     e = 4'b1011;
            else if (i >= 2*GAP + 6 && i <= 2*GAP + 8) e = 4'b1011;
            else                                       e = 4'hF;
            if (row !== e) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
            if (busy !== ~cmd_ready) bsy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (d1 < 0) begin
                    d1 = i;
                    rdy_at_d1 = cmd_ready;
                end else if (d2 < 0) begin
                    d2 = i;
                end
            end
        end
        cmd_valid = 1'b0;
        col = 4'hF;
        checks++; if (mism !== 0)        begin fails++; $display("FAIL handshake_trace: %0d bad cycles (first at %0d) required 0", mism, first_bad); end
        checks++; if (done_cnt !== 2)    begin fails++; $display("FAIL handshake_done_count: got %0d required 2", done_cnt); end
        checks++; if (d1 !== GAP + 1)    begin fails++; $display("FAIL handshake_done1: got %0d required %0d", d1, GAP + 1); end
        checks++; if (d2 !== 2*GAP + 5)  begin fails++; $display("FAIL handshake_done2: got %0d required %0d", d2, 2*GAP + 5); end
        checks++; if (rdy_at_d1 !== 1)   begin fails++; $display("FAIL handshake_ready_at_done: got %b required 1", rdy_at_d1); end
        checks++; if (bsy_bad !== 0)     begin fails++; $display("FAIL handshake_busy: busy differed from ~cmd_ready, required never"); end
    endtask

    task automatic test_mid_reset;
        int dn, mism, first_bad;
        logic [3:0] e;
        dn = 0; mism = 0; first_bad = -1;
        wait_idle("mid_reset");
        col = 4'b1101; cmd_key = 4'h5; cmd_hold = 16'd200; cmd_bounce = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (row !== 4'b1101) begin fails++; $display("FAIL midrst_held_row: got %b required 1101", row); end
        #1 reset = 1'b0;
        #1;
        checks++; if (row !== 4'hF)    begin fails++; $display("FAIL midrst_async_row: got %h required F", row); end
        checks++; if (cmd_ready !== 1) begin fails++; $display("FAIL midrst_ready: got %b required 1", cmd_ready); end
        checks++; if (busy !== 0)      begin fails++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (done === 1'b1) dn++;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        // Seed 8'hA5 has low bits 01, so a bounced press right after release bounces once.
        reset = 1'b1; cmd_key = 4'h5; cmd_hold = 16'd5; cmd_bounce = 1'b1; col = 4'b1101; cmd_valid = 1'b1;
        for (int i = 0; i < 2*BP + 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (done === 1'b1) dn++;
            e = (i >= BP && i < 2*BP) ? 4'hF : 4'b1101;
            if (row !== e) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
        end
        col = 4'hF;
        checks++; if (dn !== 0)   begin fails++; $display("FAIL midrst_no_done: got %0d pulses required 0", dn); end
        checks++; if (mism !== 0) begin fails++; $display("FAIL midrst_lfsr_restart: %0d bad cycles (first at %0d) required 0", mism, first_bad); end
        wait_idle("mid_reset_end");
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_keymap();
        test_bounce();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
